// File: rtl/countdown_timer_pkg.sv
// Shared state encodings for the countdown timer.
// Optional build macro: COUNTDOWN_TIMER_AUTO_RELOAD_EN (see countdown_timer_fsm).
package countdown_timer_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_RUN_ENC   = 2'd1;
    localparam logic [1:0] ST_PAUSE_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_RUN   = ST_RUN_ENC,
        ST_PAUSE = ST_PAUSE_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

endpackage

// File: rtl/countdown_timer_fsm.sv
// Control FSM: next state, datapath strobes and the registered done pulse.
// COUNTDOWN_TIMER_AUTO_RELOAD_EN: terminal count reloads and stays in RUN.
module countdown_timer_fsm
    import countdown_timer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic start,
    input  logic stop,
    input  logic cnt_zero,
    input  logic cnt_one,
    input  logic rld_zero,
    output logic do_load,
    output logic do_dec,
    output logic do_reload,
    output logic busy,
    output logic done
);

    state_t state;
    state_t state_nxt;
    logic   done_nxt;
    logic   go;

    // stop outranks start in every state
    assign go = start && !stop;

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        do_dec    = 1'b0;
        do_reload = 1'b0;
        done_nxt  = 1'b0;
        if (load) begin
            do_load   = 1'b1;
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go && !cnt_zero)
                        state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (stop) begin
                        state_nxt = ST_PAUSE;
                    end else if (cnt_zero) begin
                        state_nxt = ST_DONE;
                    end else if (cnt_one) begin
                        done_nxt = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
                        do_reload = 1'b1;
`else
                        do_dec    = 1'b1;
                        state_nxt = ST_DONE;
`endif
                    end else begin
                        do_dec = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (go)
                        state_nxt = ST_RUN;
                end
                ST_DONE: begin
                    if (go) begin
                        do_reload = 1'b1;
                        if (!rld_zero)
                            state_nxt = ST_RUN;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    assign busy = (state == ST_RUN);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer top: count/reload datapath around countdown_timer_fsm.
// Build option COUNTDOWN_TIMER_AUTO_RELOAD_EN selects periodic mode.
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [SIZE-1:0] load_value,
    input  logic            start,
    input  logic            stop,
    output logic [SIZE-1:0] count,
    output logic            busy,
    output logic            done
);

    localparam logic [SIZE-1:0] ONE = SIZE'(1);

    logic [SIZE-1:0] reload;
    logic            do_load;
    logic            do_dec;
    logic            do_reload;
    logic            cnt_zero;
    logic            cnt_one;
    logic            rld_zero;

    assign cnt_zero = (count == '0);
    assign cnt_one  = (count == ONE);
    assign rld_zero = (reload == '0);

    countdown_timer_fsm u_fsm (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .start     (start),
        .stop      (stop),
        .cnt_zero  (cnt_zero),
        .cnt_one   (cnt_one),
        .rld_zero  (rld_zero),
        .do_load   (do_load),
        .do_dec    (do_dec),
        .do_reload (do_reload),
        .busy      (busy),
        .done      (done)
    );

    // FSM never asserts do_dec at zero, so count cannot wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count  <= '0;
            reload <= '0;
        end else if (do_load) begin
            count  <= load_value;
            reload <= load_value;
        end else if (do_reload) begin
            count  <= reload;
        end else if (do_dec) begin
            count  <= count - ONE;
        end
    end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter SIZE, default 4, meaning count, reload and load_value width in bits.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port reset  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port load  input  1  capture load_value into count and the reload register.
REQ-005 SHALL have port load_value  input  SIZE  start value for the countdown.
REQ-006 SHALL have port start  input  1  begin or resume counting.
REQ-007 SHALL have port stop  input  1  pause counting.
REQ-008 SHALL have port count  output  SIZE  current remaining count, registered.
REQ-009 SHALL have port busy  output  1  high exactly while the state is RUN.
REQ-010 SHALL have port done  output  1  single-cycle registered pulse on terminal count.

Function
REQ-011 SHALL implement states IDLE, RUN, PAUSE and DONE; all inputs are sampled on the clk rising edge.
REQ-012 SHALL apply input priority load > stop > start when inputs are asserted in the same cycle.
REQ-013 SHALL, on load in any state, set count = load_value, set reload register = load_value, enter IDLE and keep done low.
REQ-014 SHALL, on start in IDLE with count != 0, enter RUN; start in IDLE with count == 0 SHALL be ignored.
REQ-015 SHALL, in RUN, decrement count by 1 every cycle, with the subtraction carried out at SIZE bits.
REQ-016 SHALL, in RUN with count == 1, set count = 0, pulse done for exactly one cycle and enter DONE.
REQ-017 SHALL assert done N cycles after the start edge for count N, with no extra latency.
REQ-018 SHALL, on stop in RUN, enter PAUSE and hold count; stop in IDLE, PAUSE or DONE SHALL have no effect.
REQ-019 SHALL, on start in PAUSE, resume RUN from the held count; simultaneous start and stop SHALL remain in or enter PAUSE.
REQ-020 SHALL, on start in DONE, reload count from the reload register and enter RUN if the reload value != 0, else stay in DONE.
REQ-021 SHALL never underflow: count SHALL not wrap from 0 to 2^SIZE-1.
REQ-022 SHALL accept load_value = 2^SIZE-1 and count it down in full.

Reset
REQ-023 SHALL, while reset is low, asynchronously force state = IDLE, count = 0, reload register = 0, busy = 0 and done = 0.
REQ-024 SHALL, on reset mid-RUN, abandon the countdown with no done pulse, and ignore start until the next load.

Configuration
REQ-025 SHALL support macro COUNTDOWN_TIMER_AUTO_RELOAD_EN.
REQ-026 SHALL, with COUNTDOWN_TIMER_AUTO_RELOAD_EN defined, at terminal count in RUN, set count = reload register, pulse done and remain in RUN, giving a period of N cycles.
REQ-027 SHALL, without COUNTDOWN_TIMER_AUTO_RELOAD_EN, behave per REQ-016 as a one-shot.
REQ-028 SHALL, with the macro defined, still honour stop, load and reset exactly as in the one-shot build.

Structure
REQ-029 SHALL place the state enumeration typedef and state encodings in shared package countdown_timer_pkg.
REQ-030 SHALL implement the next-state logic in sub-module countdown_timer_fsm, with the datapath (count and reload registers) kept in countdown_timer.

Verification
REQ-031 SHALL cover: load 5, start at cycle 0 -> count 4,3,2,1,0 at cycles 1..5, done high at cycle 5 only, busy low from cycle 5.
REQ-032 SHALL cover: load 6, start, stop at count 3 for 4 cycles, then start -> count holds 3 for the pause, done 3 cycles after the resume edge.
REQ-033 SHALL cover: load 0, start -> state stays IDLE, busy 0, done never asserts; load 15, start -> done after 15 cycles with no wrap.
REQ-034 SHALL cover: same-cycle load 9/stop/start while RUN -> count 9, state IDLE; same-cycle start and stop in PAUSE -> stays in PAUSE.
REQ-035 SHALL cover: reset low mid-RUN at count 2 -> count 0 and busy 0 immediately, no done pulse; start after reset release ignored.
REQ-036 SHALL cover: with AUTO_RELOAD_EN, load 3, start -> done pulses every 3 cycles and count cycles 2,1,3,2,1,3 until stop.
